// File: rtl/vproc_pkg.sv
// Shared vector-processor configuration types.
package vproc_pkg;

  typedef enum logic [1:0] {
    EMUL_1 = 2'd0,
    EMUL_2 = 2'd1,
    EMUL_4 = 2'd2,
    EMUL_8 = 2'd3
  } cfg_emul;

endpackage

// File: rtl/vproc_pending_wr_mask.sv
// Combinational decode of an instruction's destination register group into a vreg mask.
module vproc_pending_wr_mask
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_CNT = 32
) (
  input  logic [$clog2(VREG_CNT)-1:0] rd_i,
  input  cfg_emul                     emul_i,
  input  logic [2:0]                  nf_i,
  input  logic                        lsu_i,
  input  logic                        narrow_i,
  input  logic                        single_i,
  input  logic                        nowr_i,
  output logic [VREG_CNT-1:0]         mask_o,
  output logic                        illegal_o
);

  localparam int unsigned RD_W = $clog2(VREG_CNT);
  localparam logic [VREG_CNT-1:0] ONE = VREG_CNT'(1);

  logic                emul_ok;
  logic [1:0]          emul_log;
  logic [1:0]          grp_log;
  logic [3:0]          grp_size;
  logic [6:0]          lsu_cnt;
  logic [RD_W-1:0]     base;
  logic [VREG_CNT-1:0] ones;

  always_comb begin
    emul_ok  = 1'b1;
    emul_log = 2'd0;
    case (emul_i)
      EMUL_1:  emul_log = 2'd0;
      EMUL_2:  emul_log = 2'd1;
      EMUL_4:  emul_log = 2'd2;
      EMUL_8:  emul_log = 2'd3;
      default: emul_ok  = 1'b0;
    endcase
    lsu_cnt  = ({4'd0, nf_i} + 7'd1) << emul_log;
    grp_log  = (narrow_i && emul_log != 2'd0) ? emul_log - 2'd1 : emul_log;
    grp_size = 4'd1 << grp_log;
    mask_o    = '0;
    illegal_o = 1'b0;
    ones      = '0;
    base      = '0;
    if (nowr_i) begin
      mask_o = '0;
    end else if (single_i) begin
      mask_o = ONE << rd_i;
    end else if (!emul_ok) begin
      mask_o = '0;
    end else if (lsu_i) begin
      // Segment loads align to EMUL, not to the full field count
      if (lsu_cnt > 7'd8) begin
        illegal_o = 1'b1;
      end else begin
        ones   = (ONE << lsu_cnt) - ONE;
        base   = (rd_i >> emul_log) << emul_log;
        mask_o = ones << base;
      end
    end else begin
      ones   = (ONE << grp_size) - ONE;
      base   = (rd_i >> grp_log) << grp_log;
      mask_o = ones << base;
    end
  end

endmodule

// File: rtl/vproc_pending_wr_tracker.sv
// Saturating per-vreg scoreboard of outstanding writes; drives RAW/WAW stall info to the dispatcher.
module vproc_pending_wr_tracker
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_CNT  = 32,
  parameter int unsigned RET_PORTS = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                          clk_i,
  input  logic                          async_rst_ni,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [$clog2(VREG_CNT)-1:0]   issue_rd_i,
  input  cfg_emul                       issue_emul_i,
  input  logic [2:0]                    issue_nf_i,
  input  logic                          issue_lsu_i,
  input  logic                          issue_narrow_i,
  input  logic                          issue_single_i,
  input  logic                          issue_nowr_i,
  input  logic [RET_PORTS-1:0]          ret_valid_i,
  input  logic [RET_PORTS*VREG_CNT-1:0] ret_mask_i,
  output logic [VREG_CNT-1:0]           pending_wr_o,
  output logic [VREG_CNT-1:0]           issue_mask_o,
  output logic                          illegal_o,
  output logic                          underflow_o
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [VREG_CNT-1:0] mask;
  logic [VREG_CNT-1:0] full;
  logic [VREG_CNT-1:0] under;
  logic                dec_illegal;
  logic                accept;
  logic                illegal_reg;
  logic                underflow_reg;

  vproc_pending_wr_mask #(
    .VREG_CNT (VREG_CNT)
  ) u_mask (
    .rd_i      (issue_rd_i),
    .emul_i    (issue_emul_i),
    .nf_i      (issue_nf_i),
    .lsu_i     (issue_lsu_i),
    .narrow_i  (issue_narrow_i),
    .single_i  (issue_single_i),
    .nowr_i    (issue_nowr_i),
    .mask_o    (mask),
    .illegal_o (dec_illegal)
  );

  // Ready deliberately ignores same-cycle retires to keep retire off the ready path
  assign issue_ready_o = !flush_i && !(|(mask & full));
  assign accept        = issue_valid_i && issue_ready_o;
  assign issue_mask_o  = mask;

  genvar gi;
  generate
    for (gi = 0; gi < VREG_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic [SUM_W-1:0] dec;
      logic [SUM_W-1:0] sum;

      always_comb begin
        dec = '0;
        for (int p = 0; p < RET_PORTS; p++) begin
          dec = dec + {{(SUM_W-1){1'b0}}, ret_valid_i[p] & ret_mask_i[p*VREG_CNT + gi]};
        end
        sum = {2'b00, cnt_reg} + {{(SUM_W-1){1'b0}}, accept & mask[gi]} - dec;
        under[gi] = sum[SUM_W-1];
        if (sum[SUM_W-1]) begin
          cnt_next = '0;
        end else if (sum > {2'b00, CNT_MAX}) begin
          cnt_next = CNT_MAX;
        end else begin
          cnt_next = sum[CNT_W-1:0];
        end
      end

      always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
          cnt_reg <= '0;
        end else if (flush_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign full[gi]         = (cnt_reg == CNT_MAX);
      assign pending_wr_o[gi] = (cnt_reg != '0);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      illegal_reg   <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush_i) begin
      illegal_reg   <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      illegal_reg   <= accept && dec_illegal;
      underflow_reg <= underflow_reg || (|under);
    end
  end

  assign illegal_o   = illegal_reg;
  assign underflow_o = underflow_reg;

endmodule
